mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters: SIZE, default 32, data/address width; NUMB, default 256, memory depth in words.
REQ-002 CLK  input  1  clock; all state updates on posedge CLK.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  CPU request present.
REQ-005 req_ready  output  1  unit accepts a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal.
REQ-008 req_sign  input  1  sign-extend sub-word loads.
REQ-009 req_addr  input  SIZE  byte address.
REQ-010 req_wdata  input  SIZE  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle response pulse.
REQ-012 resp_rdata  output  SIZE  load result, extended.
REQ-013 resp_err  output  1  request rejected; qualified by resp_valid.
REQ-014 mem_addr  output  SIZE  word index to the memory (req_addr >> 2).
REQ-015 mem_we  output  1  memory write enable; the memory commits on the negedge of the same cycle.
REQ-016 mem_wdata  output  SIZE  write word to the memory.
REQ-017 mem_rdata  input  SIZE  combinational read data from the memory.

Function
REQ-018 FSM states: IDLE, RD, WR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 Accept: req_valid && req_ready at a posedge latches we, size, sign, addr, and wdata; inputs are ignored until the next IDLE.
REQ-020 Error: misalignment (half with addr[0]=1, word with addr[1:0]!=0), size=3, or word index >= NUMB routes IDLE->RESP with resp_err=1, never enters RD or WR, and asserts no mem_we.
REQ-021 Load path: IDLE->RD->RESP; mem_rdata is sampled at the posedge ending RD; resp_valid rises 2 cycles after accept.
REQ-022 Word store path: IDLE->WR->RESP; mem_wdata = wdata.
REQ-023 Sub-word store path (read-modify-write): IDLE->RD->WR->RESP; the lane selected by addr[1:0] (byte) or addr[1] (half) is replaced and other lanes are preserved from the RD sample.
REQ-024 mem_we = (state==WR) && !RST, combinational, so an RST raised during WR suppresses the negedge write; it is high for exactly one cycle per store.
REQ-025 mem_addr holds the latched word index in RD and WR, and is 0 otherwise.
REQ-026 Load extraction: byte lane = addr[1:0]*8, half lane = addr[1]*16; sign- or zero-extend per the latched sign; for word loads, sign is ignored.
REQ-027 resp_valid is high for exactly one cycle (RESP), with no backpressure; RESP->IDLE unconditionally.
REQ-028 resp_rdata = 0 for stores and errors; it holds its value only while resp_valid is high and is 0 otherwise.
REQ-029 Back-to-back: a new request may be accepted on the cycle after RESP; there is no overlap.

Reset
REQ-030 RST at any posedge: state=IDLE and resp_valid=0; resp_err, resp_rdata, mem_addr, mem_wdata and all latches are 0; an in-flight request is dropped without a response.
REQ-031 After RST deasserts, req_ready=1 on the first cycle.

Structure
REQ-032 Shared package: state encoding (IDLE=0, RD=1, WR=2, RESP=3), size codes (BYTE=0, HALF=1, WORD=2), SIZE and NUMB defaults.
REQ-033 One sub-module, lane_merge: combinational lane insert (store) and extract/extend (load), reused by both paths.

Verification (bench memory initialised with Mem[i]=i, writes on negedge)
REQ-034 Word load addr 0x10 -> resp_valid 2 cycles after accept; rdata=0x00000004, err=0.
REQ-035 Byte store 0xF0 at 0x0D, then signed byte load 0x0D -> Mem[3]=0x0000F003, rdata=0xFFFFFFF0; an unsigned load gives 0x000000F0.
REQ-036 Half load at addr 0x03 -> IDLE->RESP, err=1, mem_we never high, rdata=0.
REQ-037 Word store to addr 0x400 (index 256) -> err=1, no write; Mem[255] is unchanged.
REQ-038 RST asserted during the WR cycle of a word store 0xDEADBEEF to 0x08 -> mem_we low, Mem[2] stays 2, no resp_valid, req_ready=1 the cycle after reset.
REQ-039 Three back-to-back requests (store, load, error) with req_valid held high -> each accepted only in IDLE; exactly three resp_valid pulses, in order.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared state encoding, size codes and defaults for mem_access_unit
//
// Contents:
//   state_t       FSM state encoding (IDLE=0, RD=1, WR=2, RESP=3)
//   SZ_*          request size codes (BYTE=0, HALF=1, WORD=2; 3 is illegal)
//   DEF_SIZE      default data/address width
//   DEF_NUMB      default memory depth in words
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int DEF_SIZE = 32;
    localparam int DEF_NUMB = 256;

endpackage

// File: rtl/mem_access_unit_lane_merge.sv
// rtl/mem_access_unit_lane_merge.sv - combinational lane insert (store) and extract/extend (load)
//
// Ports:
//   word_in    full memory word (RD sample for stores, live read data for loads)
//   sub_data   right-aligned store data
//   size       size code (byte/half/word)
//   sign       sign-extend sub-word loads
//   byte_off   byte offset within the word (addr[1:0])
//   merged     word_in with the selected lane replaced by sub_data
//   extracted  selected lane of word_in, right-aligned and extended
module lane_merge
    import mem_access_unit_pkg::*;
#(
    parameter int SIZE = DEF_SIZE
) (
    input  logic [SIZE-1:0] word_in,
    input  logic [SIZE-1:0] sub_data,
    input  logic [1:0]      size,
    input  logic            sign,
    input  logic [1:0]      byte_off,
    output logic [SIZE-1:0] merged,
    output logic [SIZE-1:0] extracted
);

    logic [5:0]      sh;
    logic [SIZE-1:0] lane_mask;
    logic [SIZE-1:0] shifted;

    always_comb begin
        sh        = '0;
        lane_mask = '1;
        case (size)
            SZ_BYTE: begin
                sh        = {1'b0, byte_off, 3'b000};
                lane_mask = SIZE'(8'hFF) << sh;
            end
            SZ_HALF: begin
                sh        = {1'b0, byte_off[1], 4'b0000};
                lane_mask = SIZE'(16'hFFFF) << sh;
            end
            default: begin
                // Word access: whole word, no shift.
            end
        endcase

        merged  = (word_in & ~lane_mask) | ((sub_data << sh) & lane_mask);
        shifted = word_in >> sh;

        case (size)
            SZ_BYTE: extracted = {{(SIZE-8){sign & shifted[7]}}, shifted[7:0]};
            SZ_HALF: extracted = {{(SIZE-16){sign & shifted[15]}}, shifted[15:0]};
            default: extracted = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding CPU load/store unit with sub-word read-modify-write
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we, req_size,
//   req_sign, req_addr,
//   req_wdata                request fields, latched at accept
//   resp_valid               one-cycle response pulse
//   resp_rdata, resp_err     load result / rejection flag, zero outside resp_valid
//   mem_addr, mem_we,
//   mem_wdata, mem_rdata     word-indexed memory port; memory writes on the negedge
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int SIZE = DEF_SIZE,
    parameter int NUMB = DEF_NUMB
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_sign,
    input  logic [SIZE-1:0] req_addr,
    input  logic [SIZE-1:0] req_wdata,
    output logic            resp_valid,
    output logic [SIZE-1:0] resp_rdata,
    output logic            resp_err,
    output logic [SIZE-1:0] mem_addr,
    output logic            mem_we,
    output logic [SIZE-1:0] mem_wdata,
    input  logic [SIZE-1:0] mem_rdata
);

    state_t state, next_state;

    logic            lat_we;
    logic [1:0]      lat_size;
    logic            lat_sign;
    logic [SIZE-1:0] lat_addr;
    logic [SIZE-1:0] lat_wdata;
    logic [SIZE-1:0] rd_sample;
    logic            resp_err_q;
    logic [SIZE-1:0] resp_rdata_q;

    logic [SIZE-1:0] req_idx;
    logic            req_err;
    logic            accept;
    logic [SIZE-1:0] lane_word;
    logic [SIZE-1:0] merged;
    logic [SIZE-1:0] extracted;

    assign req_idx = req_addr >> 2;
    assign req_err = (req_size == 2'd3)
                  || (req_size == SZ_HALF && req_addr[0])
                  || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                  || (req_idx >= SIZE'(NUMB));
    assign accept  = req_valid && (state == ST_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        next_state = ST_RESP;
                    end else if (req_we && req_size == SZ_WORD) begin
                        next_state = ST_WR;
                    end else begin
                        // Loads and sub-word stores both need the current word first.
                        next_state = ST_RD;
                    end
                end
            end
            ST_RD:   next_state = lat_we ? ST_WR : ST_RESP;
            ST_WR:   next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            lat_we       <= 1'b0;
            lat_size     <= '0;
            lat_sign     <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            rd_sample    <= '0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_size  <= req_size;
                lat_sign  <= req_sign;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (state == ST_RD) begin
                rd_sample <= mem_rdata;
            end
            // Both response registers are only non-zero during the RESP cycle.
            resp_err_q   <= accept && req_err;
            resp_rdata_q <= (state == ST_RD && !lat_we) ? extracted : '0;
        end
    end

    // Stores merge into the RD snapshot; loads extract from live read data.
    assign lane_word = (state == ST_WR) ? rd_sample : mem_rdata;

    lane_merge #(
        .SIZE (SIZE)
    ) u_lane_merge (
        .word_in   (lane_word),
        .sub_data  (lat_wdata),
        .size      (lat_size),
        .sign      (lat_sign),
        .byte_off  (lat_addr[1:0]),
        .merged    (merged),
        .extracted (extracted)
    );

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

    // RST gates the write so a reset during WR suppresses the negedge commit.
    assign mem_we    = (state == ST_WR) && !RST;
    assign mem_addr  = (state == ST_RD || state == ST_WR) ? (lat_addr >> 2) : '0;
    assign mem_wdata = (state == ST_WR) ? merged : '0;

endmodule
